// File: rtl/fifo_uart_pkg.sv
// Shared types and default sizing for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state to the state type.
package fifo_uart_pkg;

    localparam int DEFAULT_WIDTH        = 16;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Upstream FIFO read port plus serial/status outputs of fifo_uart_tx.
// Handshake: empty_i low means data_i is a valid head word; read_en_o is a
// one-cycle pop strobe and the word counts as consumed on the edge it is high.
interface fifo_uart_tx_if #(
    parameter int WIDTH = 16
);
    logic             empty_i;
    logic [WIDTH-1:0] data_i;
    logic             read_en_o;
    logic             tx_o;
    logic             busy_o;
    logic [2:0]       state_o;

    modport master (
        output empty_i, data_i,
        input  read_en_o, tx_o, busy_o, state_o
    );

    modport slave (
        input  empty_i, data_i,
        output read_en_o, tx_o, busy_o, state_o
    );
endinterface

// File: rtl/baud_tick.sv
// Bit-time counter: one-cycle tick every CLKS_PER_BIT enabled cycles,
// held at zero while disabled.
module baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from an upstream FIFO and sends them LSB first.
// Define FIFO_UART_TX_PARITY_EN to append an even-parity bit before the stop bit.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic           clk_i,
    input  logic           reset_i,
    fifo_uart_tx_if.slave  bus
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             rd_q, rd_d;
    logic             tick;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (state_q != ST_IDLE),
        .tick_o  (tick)
    );

    // Line outputs are registered from the current state, so they trail the
    // state by one cycle; this leaves the pop cycle as the single idle gap.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        rd_d    = 1'b0;
        tx_d    = 1'b1;
        busy_d  = (state_q != ST_IDLE);
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!bus.empty_i) begin
                    rd_d    = 1'b1;
                    shift_d = bus.data_i;
`ifdef FIFO_UART_TX_PARITY_EN
                    par_d   = ^bus.data_i;
`endif
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_d = par_q;
                if (tick) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (tick) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            rd_q    <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            rd_q    <= rd_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.read_en_o = rd_q;
    assign bus.tx_o      = tx_q;
    assign bus.busy_o    = busy_q;
    assign bus.state_o   = state_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-backed FIFO feeds random words while a
// frame-level model predicts the pop strobe and the busy/tx waveform each cycle.
module tb_fifo_uart_tx;
  localparam int W   = 16;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  fifo_uart_tx_if #(.WIDTH(W)) bus ();

  fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] fifo_q[$];
  logic [1:0]   exp_q[$];
  logic         hide_empty  = 1'b0;
  logic         rst_at_edge = 1'b1;
  logic         empty_at_edge = 1'b1;
  logic [W-1:0] data_at_edge = '0;
  logic         prev_rd = 1'b0;
  logic         seen_rd = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {busy, tx} for every cycle of one frame, starting the cycle after the pop.
  task automatic push_frame(input logic [W-1:0] w);
    for (int k = 0; k < CPB; k++) exp_q.push_back(2'b10);
    for (int i = 0; i < W; i++)
      for (int k = 0; k < CPB; k++) exp_q.push_back({1'b1, w[i]});
`ifdef FIFO_UART_TX_PARITY_EN
    for (int k = 0; k < CPB; k++) exp_q.push_back({1'b1, ^w});
`endif
    for (int k = 0; k < CPB; k++) exp_q.push_back(2'b11);
  endtask

  // Check the current cycle at the falling edge, then drive inputs for the next rising edge.
  task automatic cycle(input logic rst);
    logic exp_rd;
    logic [1:0] exp_bt;
    @(negedge clk);
    if (rst_at_edge) begin
      exp_q.delete();
      exp_rd = 1'b0;
    end else begin
      exp_rd = !empty_at_edge && (exp_q.size() == 0) && !prev_rd;
    end
    check_eq("read_en", {31'd0, bus.read_en_o}, {31'd0, exp_rd});
    exp_bt = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b01;
    check_eq("busy_tx", {30'd0, bus.busy_o, bus.tx_o}, {30'd0, exp_bt});
    if (exp_rd) push_frame(data_at_edge);
    seen_rd = bus.read_en_o;
    if (bus.read_en_o && fifo_q.size() > 0) void'(fifo_q.pop_front());
    prev_rd = exp_rd;

    reset_i     = rst;
    bus.empty_i = hide_empty || (fifo_q.size() == 0);
    bus.data_i  = (fifo_q.size() > 0) ? fifo_q[0] : W'($urandom);
    rst_at_edge   = rst;
    empty_at_edge = bus.empty_i;
    data_at_edge  = bus.data_i;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  task automatic wait_pop(input int budget);
    int i;
    i = 0;
    seen_rd = 1'b0;
    while (!seen_rd && i < budget) begin
      cycle(1'b0);
      i++;
    end
    check_eq("pop_seen", {31'd0, seen_rd}, 32'd1);
  endtask

  initial begin
    reset_i     = 1'b1;
    bus.empty_i = 1'b1;
    bus.data_i  = '0;

    // Reset held two edges, then an empty FIFO for 20 cycles.
    cycle(1'b1);
    cycle(1'b0);
    run(20);

    // Single word.
    fifo_q.push_back(16'hbeef);
    run(80);

    // Four queued words back to back.
    fifo_q.push_back(16'hbeef);
    fifo_q.push_back(16'hceef);
    fifo_q.push_back(16'hdeef);
    fifo_q.push_back(16'heeef);
    run(4 * 73 + 10);

    // Reset during data bit 5; the following word must go out whole.
    fifo_q.push_back(16'h1234);
    fifo_q.push_back(16'ha5c3);
    wait_pop(10);
    for (int i = 0; i < 24; i++) cycle(1'b0);
    cycle(1'b1);
    run(90);

    // Random traffic with mid-frame empty toggles, garbage data and rare resets.
    for (int i = 0; i < 3200; i++) begin
      if ($urandom_range(0, 39) == 0) fifo_q.push_back(W'($urandom));
      hide_empty = ($urandom_range(0, 7) == 0);
      cycle($urandom_range(0, 699) == 0);
    end
    hide_empty = 1'b0;

    // Drain whatever is still queued, bounded.
    for (int i = 0; i < 4000 && (fifo_q.size() > 0 || exp_q.size() > 0); i++) cycle(1'b0);
    check_eq("drained", {31'd0, (fifo_q.size() == 0 && exp_q.size() == 0)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits; SHALL be >= 2.
REQ-002 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit time; SHALL be >= 2.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_i  input  1  reset, synchronous, active-high.
REQ-005 empty_i  input  1  upstream FIFO empty flag; low means data_i holds the head word.
REQ-006 data_i  input  WIDTH  upstream FIFO head word, valid whenever empty_i is low.
REQ-007 read_en_o  output  1  one-cycle pop strobe to upstream FIFO read_en.
REQ-008 tx_o  output  1  serial line, idle high.
REQ-009 busy_o  output  1  high while a frame is in progress.

Function
REQ-010 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY exists only per REQ-024.
REQ-011 In IDLE with empty_i low, block SHALL assert read_en_o for exactly one cycle, capture data_i into the shift register on that edge, and enter START.
REQ-012 read_en_o SHALL never be asserted while empty_i is high or outside IDLE.
REQ-013 tx_o, read_en_o, busy_o SHALL be registered; tx_o drops low the cycle after read_en_o is high.
REQ-014 START: tx_o low for CLKS_PER_BIT cycles.
REQ-015 DATA: WIDTH bits, LSB first, each held CLKS_PER_BIT cycles.
REQ-016 STOP: tx_o high for CLKS_PER_BIT cycles, then IDLE.
REQ-017 IDLE SHALL last at least one cycle between frames; back-to-back frame period = (WIDTH+2)*CLKS_PER_BIT+1 cycles (+CLKS_PER_BIT with parity).
REQ-018 busy_o SHALL be high in every state except IDLE, and high from the cycle tx_o first goes low.
REQ-019 Bit-time counter SHALL be $clog2(CLKS_PER_BIT) bits, wrap at CLKS_PER_BIT-1; bit index $clog2(WIDTH) bits, wrap at WIDTH-1.
REQ-020 Changes on empty_i/data_i mid-frame SHALL not affect the frame in flight.

Reset
REQ-021 reset_i high at a clock edge SHALL force IDLE, tx_o=1, read_en_o=0, busy_o=0, counters and shift register to 0 on that edge.
REQ-022 Reset mid-frame SHALL abort the frame; the popped word is discarded, no further read_en_o until reset deasserts.
REQ-023 First pop after reset SHALL occur no earlier than the first edge with reset_i low.

Configuration
REQ-024 Macro FIFO_UART_TX_PARITY_EN defined: PARITY state inserted between DATA and STOP, tx_o = even parity (XOR of all WIDTH data bits) for CLKS_PER_BIT cycles.
REQ-025 Macro undefined: no PARITY state or parity logic; DATA goes directly to STOP.

Structure
REQ-026 Package fifo_uart_pkg SHALL hold the state enum type and the default WIDTH/CLKS_PER_BIT constants.
REQ-027 Sub-module baud_tick SHALL hold the bit-time counter, emitting a one-cycle tick every CLKS_PER_BIT cycles while enabled and clearing when disabled.

Verification (WIDTH=16, CLKS_PER_BIT=4)
REQ-028 Reset 2 cycles, empty_i high 20 cycles -> tx_o=1, busy_o=0, read_en_o=0 throughout.
REQ-029 One word 16'hbeef -> read_en_o single pulse; tx_o low 4 cycles, then bits 1111 0111 0111 1101 (4 cycles each), high 4 cycles; 72-cycle frame, busy_o high all 72.
REQ-030 Four words beef/ceef/deef/eeef queued -> four pops, frames separated by exactly one IDLE cycle, period 73 cycles, correct bit order each.
REQ-031 reset_i pulsed in DATA bit 5 -> next edge tx_o=1, busy_o=0, no pop until after reset; next queued word sent complete.
REQ-032 FIFO_UART_TX_PARITY_EN defined, 16'hbeef -> parity bit 1 for 4 cycles before stop; 76-cycle frame.
REQ-033 empty_i toggled mid-frame and data_i changed -> no extra read_en_o, transmitted bits unchanged.
